// File: rtl/axi_to_stream_pkg.sv
// Shared types and constants for the AXI4 snoop-to-AXI-Stream bridge.
package axi_to_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_DATA = 2'd2
    } state_e;

    // What the slot currently holds, which selects the AXI channel it drives
    typedef enum logic [1:0] {
        KIND_AW = 2'd0,
        KIND_AR = 2'd1,
        KIND_W  = 2'd2,
        KIND_R  = 2'd3
    } kind_e;

    localparam int   TUSER_HDR = 1;
    localparam int   TUSER_DIR = 0;
    localparam logic DIR_WR    = 1'b0;
    localparam logic DIR_RD    = 1'b1;

    function automatic logic [1:0] tuser_f(input logic hdr, input logic dir);
        logic [1:0] t;
        t            = 2'b00;
        t[TUSER_HDR] = hdr;
        t[TUSER_DIR] = dir;
        return t;
    endfunction

endpackage

// File: rtl/axi_to_stream.sv
// AXI4 pass-through that copies every transaction (header + data beats) onto
// an AXI-Stream snoop port through a single two-consumer slot.
module axi_to_stream
    import axi_to_stream_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    // upstream slave port
    input  logic [ID_W-1:0]     s_axi_awid_i,
    input  logic [ADDR_W-1:0]   s_axi_awaddr_i,
    input  logic [7:0]          s_axi_awlen_i,
    input  logic [2:0]          s_axi_awsize_i,
    input  logic [1:0]          s_axi_awburst_i,
    input  logic                s_axi_awvalid_i,
    output logic                s_axi_awready_o,
    input  logic [DATA_W-1:0]   s_axi_wdata_i,
    input  logic [DATA_W/8-1:0] s_axi_wstrb_i,
    input  logic                s_axi_wlast_i,
    input  logic                s_axi_wvalid_i,
    output logic                s_axi_wready_o,
    output logic [ID_W-1:0]     s_axi_bid_o,
    output logic [1:0]          s_axi_bresp_o,
    output logic                s_axi_bvalid_o,
    input  logic                s_axi_bready_i,
    input  logic [ID_W-1:0]     s_axi_arid_i,
    input  logic [ADDR_W-1:0]   s_axi_araddr_i,
    input  logic [7:0]          s_axi_arlen_i,
    input  logic [2:0]          s_axi_arsize_i,
    input  logic [1:0]          s_axi_arburst_i,
    input  logic                s_axi_arvalid_i,
    output logic                s_axi_arready_o,
    output logic [ID_W-1:0]     s_axi_rid_o,
    output logic [DATA_W-1:0]   s_axi_rdata_o,
    output logic [1:0]          s_axi_rresp_o,
    output logic                s_axi_rlast_o,
    output logic                s_axi_rvalid_o,
    input  logic                s_axi_rready_i,
    // downstream master port
    output logic [ID_W-1:0]     m_axi_awid_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr_o,
    output logic [7:0]          m_axi_awlen_o,
    output logic [2:0]          m_axi_awsize_o,
    output logic [1:0]          m_axi_awburst_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,
    output logic [DATA_W-1:0]   m_axi_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_wstrb_o,
    output logic                m_axi_wlast_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,
    input  logic [ID_W-1:0]     m_axi_bid_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o,
    output logic [ID_W-1:0]     m_axi_arid_o,
    output logic [ADDR_W-1:0]   m_axi_araddr_o,
    output logic [7:0]          m_axi_arlen_o,
    output logic [2:0]          m_axi_arsize_o,
    output logic [1:0]          m_axi_arburst_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    input  logic [ID_W-1:0]     m_axi_rid_i,
    input  logic [DATA_W-1:0]   m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rlast_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o,
    // snoop stream
    output logic [DATA_W-1:0]   m_axis_tdata_o,
    output logic [DATA_W/8-1:0] m_axis_tkeep_o,
    output logic [1:0]          m_axis_tuser_o,
    output logic [ID_W-1:0]     m_axis_tid_o,
    output logic                m_axis_tlast_o,
    output logic                m_axis_tvalid_o,
    input  logic                m_axis_tready_i
);

    state_e              state_q;
    kind_e               kind_q;
    logic                axi_pend_q;
    logic                axis_pend_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] keep_q;
    logic [1:0]          user_q;
    logic [ID_W-1:0]     id_q;
    logic                last_q;
    logic [1:0]          resp_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;

    logic axi_rdy_s, axi_hs_s, axis_hs_s, slot_free_s, run_s;
    logic ar_hs_s, aw_hs_s, w_hs_s, r_hs_s;

    // Ready of whichever AXI consumer the slot currently feeds
    always_comb begin
        axi_rdy_s = 1'b0;
        case (kind_q)
            KIND_AW: axi_rdy_s = m_axi_awready_i;
            KIND_AR: axi_rdy_s = m_axi_arready_i;
            KIND_W:  axi_rdy_s = m_axi_wready_i;
            KIND_R:  axi_rdy_s = s_axi_rready_i;
            default: axi_rdy_s = 1'b0;
        endcase
    end

    // aresetn is an active-high reset despite its name
    assign run_s       = ~aresetn;
    assign axi_hs_s    = axi_pend_q & axi_rdy_s;
    assign axis_hs_s   = axis_pend_q & m_axis_tready_i;
    assign slot_free_s = (~axi_pend_q | axi_hs_s) & (~axis_pend_q | axis_hs_s);

    assign s_axi_arready_o = run_s & (state_q == ST_IDLE) & slot_free_s;
    assign s_axi_awready_o = run_s & (state_q == ST_IDLE) & slot_free_s & ~s_axi_arvalid_i;
    assign s_axi_wready_o  = run_s & (state_q == ST_WR_DATA) & slot_free_s;
    assign m_axi_rready_o  = run_s & (state_q == ST_RD_DATA) & slot_free_s;

    assign ar_hs_s = s_axi_arvalid_i & s_axi_arready_o;
    assign aw_hs_s = s_axi_awvalid_i & s_axi_awready_o;
    assign w_hs_s  = s_axi_wvalid_i & s_axi_wready_o;
    assign r_hs_s  = m_axi_rvalid_i & m_axi_rready_o;

    // FSM and slot: a capture re-arms both consumers, overriding their release
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_AW;
            axi_pend_q  <= 1'b0;
            axis_pend_q <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            user_q      <= 2'b00;
            id_q        <= '0;
            last_q      <= 1'b0;
            resp_q      <= 2'b00;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
        end else begin
            if (axi_hs_s) begin
                axi_pend_q <= 1'b0;
            end
            if (axis_hs_s) begin
                axis_pend_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ar_hs_s) begin
                        kind_q      <= KIND_AR;
                        data_q      <= DATA_W'(s_axi_araddr_i);
                        keep_q      <= '1;
                        user_q      <= tuser_f(1'b1, DIR_RD);
                        id_q        <= s_axi_arid_i;
                        last_q      <= 1'b0;
                        len_q       <= s_axi_arlen_i;
                        size_q      <= s_axi_arsize_i;
                        burst_q     <= s_axi_arburst_i;
                        axi_pend_q  <= 1'b1;
                        axis_pend_q <= 1'b1;
                        state_q     <= ST_RD_DATA;
                    end else if (aw_hs_s) begin
                        kind_q      <= KIND_AW;
                        data_q      <= DATA_W'(s_axi_awaddr_i);
                        keep_q      <= '1;
                        user_q      <= tuser_f(1'b1, DIR_WR);
                        id_q        <= s_axi_awid_i;
                        last_q      <= 1'b0;
                        len_q       <= s_axi_awlen_i;
                        size_q      <= s_axi_awsize_i;
                        burst_q     <= s_axi_awburst_i;
                        axi_pend_q  <= 1'b1;
                        axis_pend_q <= 1'b1;
                        state_q     <= ST_WR_DATA;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs_s) begin
                        kind_q      <= KIND_W;
                        data_q      <= s_axi_wdata_i;
                        keep_q      <= s_axi_wstrb_i;
                        user_q      <= tuser_f(1'b0, DIR_WR);
                        last_q      <= s_axi_wlast_i;
                        axi_pend_q  <= 1'b1;
                        axis_pend_q <= 1'b1;
                        state_q     <= s_axi_wlast_i ? ST_IDLE : ST_WR_DATA;
                    end else begin
                        state_q <= ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs_s) begin
                        kind_q      <= KIND_R;
                        data_q      <= m_axi_rdata_i;
                        keep_q      <= '1;
                        user_q      <= tuser_f(1'b0, DIR_RD);
                        id_q        <= m_axi_rid_i;
                        last_q      <= m_axi_rlast_i;
                        resp_q      <= m_axi_rresp_i;
                        axi_pend_q  <= 1'b1;
                        axis_pend_q <= 1'b1;
                        state_q     <= m_axi_rlast_i ? ST_IDLE : ST_RD_DATA;
                    end else begin
                        state_q <= ST_RD_DATA;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axi_awid_o    = id_q;
    assign m_axi_awaddr_o  = data_q[ADDR_W-1:0];
    assign m_axi_awlen_o   = len_q;
    assign m_axi_awsize_o  = size_q;
    assign m_axi_awburst_o = burst_q;
    assign m_axi_awvalid_o = axi_pend_q & (kind_q == KIND_AW);
    assign m_axi_arid_o    = id_q;
    assign m_axi_araddr_o  = data_q[ADDR_W-1:0];
    assign m_axi_arlen_o   = len_q;
    assign m_axi_arsize_o  = size_q;
    assign m_axi_arburst_o = burst_q;
    assign m_axi_arvalid_o = axi_pend_q & (kind_q == KIND_AR);
    assign m_axi_wdata_o   = data_q;
    assign m_axi_wstrb_o   = keep_q;
    assign m_axi_wlast_o   = last_q;
    assign m_axi_wvalid_o  = axi_pend_q & (kind_q == KIND_W);
    assign s_axi_rid_o     = id_q;
    assign s_axi_rdata_o   = data_q;
    assign s_axi_rresp_o   = resp_q;
    assign s_axi_rlast_o   = last_q;
    assign s_axi_rvalid_o  = axi_pend_q & (kind_q == KIND_R);

    assign m_axis_tdata_o  = data_q;
    assign m_axis_tkeep_o  = keep_q;
    assign m_axis_tuser_o  = user_q;
    assign m_axis_tid_o    = id_q;
    assign m_axis_tlast_o  = last_q;
    assign m_axis_tvalid_o = axis_pend_q;

    // Write responses are not snooped, only passed through
    assign s_axi_bid_o    = m_axi_bid_i;
    assign s_axi_bresp_o  = m_axi_bresp_i;
    assign s_axi_bvalid_o = m_axi_bvalid_i & run_s;
    assign m_axi_bready_o = s_axi_bready_i & run_s;

endmodule

// File: tb/tb_axi_to_stream.sv
// Bench for axi_to_stream: AXI master stimulus, behavioural memory slave and
// a stream scoreboard of expected header/data beats.
module tb_axi_to_stream;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [1:0]  user;
        logic        id;
        logic        last;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic        s_awid, s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [3:0]  s_wstrb;
    logic        s_bid, s_bvalid, s_bready, s_arid, s_arvalid, s_arready;
    logic        s_rid, s_rlast, s_rvalid, s_rready;
    logic        m_awid, m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
    logic [3:0]  m_wstrb;
    logic        m_bid, m_bvalid, m_bready, m_arid, m_arvalid, m_arready;
    logic        m_rid, m_rlast, m_rvalid, m_rready;
    logic [31:0] t_data;
    logic [3:0]  t_keep;
    logic [1:0]  t_user;
    logic        t_id, t_last, t_valid, t_ready;

    axi_to_stream #(.ADDR_W(32), .DATA_W(32), .ID_W(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid_i(s_awid), .s_axi_awaddr_i(s_awaddr), .s_axi_awlen_i(s_awlen),
        .s_axi_awsize_i(s_awsize), .s_axi_awburst_i(s_awburst), .s_axi_awvalid_i(s_awvalid),
        .s_axi_awready_o(s_awready), .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb),
        .s_axi_wlast_i(s_wlast), .s_axi_wvalid_i(s_wvalid), .s_axi_wready_o(s_wready),
        .s_axi_bid_o(s_bid), .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid),
        .s_axi_bready_i(s_bready), .s_axi_arid_i(s_arid), .s_axi_araddr_i(s_araddr),
        .s_axi_arlen_i(s_arlen), .s_axi_arsize_i(s_arsize), .s_axi_arburst_i(s_arburst),
        .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready), .s_axi_rid_o(s_rid),
        .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rlast_o(s_rlast),
        .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready),
        .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen),
        .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst), .m_axi_awvalid_o(m_awvalid),
        .m_axi_awready_i(m_awready), .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb),
        .m_axi_wlast_o(m_wlast), .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
        .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid),
        .m_axi_bready_o(m_bready), .m_axi_arid_o(m_arid), .m_axi_araddr_o(m_araddr),
        .m_axi_arlen_o(m_arlen), .m_axi_arsize_o(m_arsize), .m_axi_arburst_o(m_arburst),
        .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready), .m_axi_rid_i(m_rid),
        .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
        .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready),
        .m_axis_tdata_o(t_data), .m_axis_tkeep_o(t_keep), .m_axis_tuser_o(t_user),
        .m_axis_tid_o(t_id), .m_axis_tlast_o(t_last), .m_axis_tvalid_o(t_valid),
        .m_axis_tready_i(t_ready)
    );

    int errors = 0;
    int n_checks = 0;
    int mode = 0;
    int phase = 0;
    int b_cnt = 0;
    logic [1:0] b_last = 2'b11;
    beat_t exp_q[$];
    beat_t got_q[$];
    logic [31:0] exp_r[$];
    logic [31:0] r_got[$];

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        return 32'hC0DE0000 | {24'h0, idx};
    endfunction

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                                 input logic [1:0] u, input logic i, input logic l);
        beat_t b;
        b = '{data: d, keep: k, user: u, id: i, last: l};
        return b;
    endfunction

    // Behavioural memory slave on m_axi: INCR bursts of 32-bit words
    bit [31:0]  mem [256];
    bit         wr_flag [256];
    logic       rd_act, wr_act, b_pend;
    logic [7:0] rd_idx, rd_cnt, wr_idx;
    logic       rd_id, wr_id;

    assign m_arready = ~rd_act;
    assign m_rvalid  = rd_act;
    assign m_rdata   = wr_flag[rd_idx] ? mem[rd_idx] : init_word(rd_idx);
    assign m_rlast   = (rd_cnt == 8'd0);
    assign m_rid     = rd_id;
    assign m_rresp   = 2'b00;
    assign m_awready = ~wr_act & ~b_pend;
    assign m_wready  = wr_act;
    assign m_bvalid  = b_pend;
    assign m_bid     = wr_id;
    assign m_bresp   = 2'b00;

    always @(posedge aclk) begin
        if (aresetn) begin
            rd_act <= 1'b0; wr_act <= 1'b0; b_pend <= 1'b0;
            rd_idx <= 8'd0; rd_cnt <= 8'd0; wr_idx <= 8'd0; rd_id <= 1'b0; wr_id <= 1'b0;
        end else begin
            if (m_arvalid && m_arready) begin
                rd_act <= 1'b1; rd_idx <= m_araddr[9:2]; rd_cnt <= m_arlen; rd_id <= m_arid;
            end else if (m_rvalid && m_rready) begin
                if (rd_cnt == 8'd0) rd_act <= 1'b0;
                else begin rd_idx <= rd_idx + 8'd1; rd_cnt <= rd_cnt - 8'd1; end
            end
            if (m_awvalid && m_awready) begin
                wr_act <= 1'b1; wr_idx <= m_awaddr[9:2]; wr_id <= m_awid;
            end else if (m_wvalid && m_wready) begin
                logic [31:0] w;
                w = wr_flag[wr_idx] ? mem[wr_idx] : init_word(wr_idx);
                for (int b = 0; b < 4; b++) if (m_wstrb[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                mem[wr_idx] <= w;
                wr_flag[wr_idx] <= 1'b1;
                wr_idx <= wr_idx + 8'd1;
                if (m_wlast) begin wr_act <= 1'b0; b_pend <= 1'b1; end
            end
            if (m_bvalid && m_bready) b_pend <= 1'b0;
        end
    end

    // Stream consumer ready pattern: 0 always high, 1 five-high/five-low, else low
    always @(posedge aclk) begin
        #1;
        case (mode)
            0: t_ready = 1'b1;
            1: begin t_ready = ((phase % 10) < 5); phase++; end
            default: t_ready = 1'b0;
        endcase
    end

    // Monitor: handshakes seen between edges complete on the next rising edge
    always @(negedge aclk) begin
        if (!aresetn) begin
            if (t_valid && t_ready) got_q.push_back(mk(t_data, t_keep, t_user, t_id, t_last));
            if (s_rvalid && s_rready) r_got.push_back(s_rdata);
            if (s_bvalid && s_bready) begin b_cnt++; b_last = s_bresp; end
        end
    end

    task automatic wait_got(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 800 && !ok; c++) begin
            @(negedge aclk);
            ok = (got_q.size() >= n);
        end
        repeat (6) @(negedge aclk);
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic id, input logic [7:0] len);
        bit hs;
        hs = 1'b0;
        @(posedge aclk); #1;
        s_araddr = a; s_arid = id; s_arlen = len; s_arvalid = 1'b1;
        for (int c = 0; c < 300 && !hs; c++) begin @(negedge aclk); hs = s_arready; end
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        n_checks++;
        if (!hs) begin errors++; $display("FAIL ar_handshake got=timeout want=accepted"); end
    endtask

    task automatic drive_w(input logic [31:0] d0, input logic [31:0] d1);
        for (int i = 0; i < 2; i++) begin
            bit hs;
            hs = 1'b0;
            s_wdata = (i == 0) ? d0 : d1; s_wstrb = 4'hF; s_wlast = (i == 1); s_wvalid = 1'b1;
            for (int c = 0; c < 300 && !hs; c++) begin @(negedge aclk); hs = s_wready; end
            @(posedge aclk); #1;
            s_wvalid = 1'b0;
            n_checks++;
            if (!hs) begin errors++; $display("FAIL w_handshake beat=%0d got=timeout want=accepted", i); end
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic id, input logic [31:0] d0,
                             input logic [31:0] d1);
        bit hs;
        hs = 1'b0;
        @(posedge aclk); #1;
        s_awaddr = a; s_awid = id; s_awlen = 8'd1; s_awvalid = 1'b1;
        for (int c = 0; c < 300 && !hs; c++) begin @(negedge aclk); hs = s_awready; end
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        n_checks++;
        if (!hs) begin errors++; $display("FAIL aw_handshake got=timeout want=accepted"); end
        drive_w(d0, d1);
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({m_awvalid, m_arvalid, m_wvalid, s_rvalid, t_valid, s_bvalid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids got=%b want=000000",
                {m_awvalid, m_arvalid, m_wvalid, s_rvalid, t_valid, s_bvalid});
        end
        n_checks++;
        if ({s_awready, s_arready, s_wready, m_rready} !== 4'b0) begin
            errors++; $display("FAIL reset_readies got=%b want=0000",
                {s_awready, s_arready, s_wready, m_rready});
        end
        n_checks++;
        if (t_data !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h want=0", t_data); end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (s_arready !== 1'b1) begin errors++; $display("FAIL idle_arready got=%b want=1", s_arready); end
    endtask

    task automatic test_read();
        bit ok;
        beat_t e, g;
        mode = 1;
        exp_q.push_back(mk(32'h100, 4'hF, 2'b11, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(init_word(8'h40 + 8'(i)), 4'hF, 2'b01, 1'b0, i == 3));
            exp_r.push_back(init_word(8'h40 + 8'(i)));
        end
        issue_ar(32'h100, 1'b0, 8'd3);
        wait_got(5, ok);
        n_checks++;
        if (got_q.size() != 5) begin errors++; $display("FAIL read_count got=%0d want=5", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin errors++; $display("FAIL read_beat got=%h want=%h", g, e); end
        end
        n_checks++;
        if (r_got.size() != 4) begin errors++; $display("FAIL read_rcount got=%0d want=4", r_got.size()); end
        while (exp_r.size() > 0 && r_got.size() > 0) begin
            logic [31:0] er, gr;
            er = exp_r.pop_front(); gr = r_got.pop_front(); n_checks++;
            if (gr !== er) begin errors++; $display("FAIL read_rdata got=%h want=%h", gr, er); end
        end
        exp_q.delete(); got_q.delete(); exp_r.delete(); r_got.delete();
        mode = 0;
    endtask

    task automatic test_write();
        bit ok;
        int b0;
        beat_t e, g;
        b0 = b_cnt;
        exp_q.push_back(mk(32'h200, 4'hF, 2'b10, 1'b0, 1'b0));
        exp_q.push_back(mk(32'hA5A5A5A5, 4'hF, 2'b00, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h5A5A5A5A, 4'hF, 2'b00, 1'b0, 1'b1));
        axi_write(32'h200, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        wait_got(3, ok);
        n_checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL write_count got=%0d want=3", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin errors++; $display("FAIL write_beat got=%h want=%h", g, e); end
        end
        n_checks++;
        if (mem[8'h80] !== 32'hA5A5A5A5 || mem[8'h81] !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL write_mem got=%h_%h want=a5a5a5a5_5a5a5a5a", mem[8'h80], mem[8'h81]);
        end
        n_checks++;
        if (b_cnt != b0 + 1 || b_last !== 2'b00) begin
            errors++; $display("FAIL write_bresp got=%0d/%b want=1/00", b_cnt - b0, b_last);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_collision();
        bit ok, ar_done, aw_done;
        beat_t e, g;
        exp_q.push_back(mk(32'h1C0, 4'hF, 2'b11, 1'b1, 1'b0));
        exp_q.push_back(mk(init_word(8'h70), 4'hF, 2'b01, 1'b1, 1'b0));
        exp_q.push_back(mk(init_word(8'h71), 4'hF, 2'b01, 1'b1, 1'b1));
        exp_q.push_back(mk(32'h240, 4'hF, 2'b10, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h11112222, 4'hF, 2'b00, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h33334444, 4'hF, 2'b00, 1'b0, 1'b1));
        ar_done = 1'b0; aw_done = 1'b0;
        @(posedge aclk); #1;
        s_araddr = 32'h1C0; s_arid = 1'b1; s_arlen = 8'd1; s_arvalid = 1'b1;
        s_awaddr = 32'h240; s_awid = 1'b0; s_awlen = 8'd1; s_awvalid = 1'b1;
        for (int c = 0; c < 300 && !(ar_done && aw_done); c++) begin
            bit ar_hs, aw_hs;
            @(negedge aclk);
            ar_hs = s_arvalid && s_arready;
            aw_hs = s_awvalid && s_awready;
            @(posedge aclk); #1;
            if (ar_hs) begin s_arvalid = 1'b0; ar_done = 1'b1; end
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1'b1; end
        end
        s_arvalid = 1'b0; s_awvalid = 1'b0;
        n_checks++;
        if (!(ar_done && aw_done)) begin
            errors++; $display("FAIL collide_hs got=%b%b want=11", ar_done, aw_done);
        end
        drive_w(32'h11112222, 32'h33334444);
        wait_got(6, ok);
        n_checks++;
        if (got_q.size() != 6) begin errors++; $display("FAIL collide_count got=%0d want=6", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin errors++; $display("FAIL collide_beat got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete(); r_got.delete();
    endtask

    task automatic test_stall();
        bit ok;
        int rc, gc;
        beat_t e, g;
        mode = 0;
        exp_q.push_back(mk(32'h140, 4'hF, 2'b11, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            exp_q.push_back(mk(init_word(8'h50 + 8'(i)), 4'hF, 2'b01, 1'b0, i == 7));
        issue_ar(32'h140, 1'b0, 8'd7);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin @(negedge aclk); ok = (got_q.size() >= 3); end
        mode = 2;
        repeat (2) @(negedge aclk);
        rc = r_got.size(); gc = got_q.size();
        repeat (20) @(negedge aclk);
        n_checks++;
        if (r_got.size() != rc || got_q.size() != gc || m_rready !== 1'b0) begin
            errors++; $display("FAIL stall_read got=%0d/%0d/%b want=%0d/%0d/0",
                r_got.size(), got_q.size(), m_rready, rc, gc);
        end
        mode = 0;
        wait_got(9, ok);
        n_checks++;
        if (got_q.size() != 9) begin errors++; $display("FAIL stall_count got=%0d want=9", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin errors++; $display("FAIL stall_beat got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete(); r_got.delete();
        // write side: header held in the slot must block wready
        exp_q.push_back(mk(32'h280, 4'hF, 2'b10, 1'b0, 1'b0));
        exp_q.push_back(mk(32'hDEADBEEF, 4'hF, 2'b00, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h0BADF00D, 4'hF, 2'b00, 1'b0, 1'b1));
        mode = 2;
        fork
            axi_write(32'h280, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
            begin
                repeat (25) @(negedge aclk);
                n_checks++;
                if (s_wready !== 1'b0 || got_q.size() != 0 || t_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_write got=%b/%0d/%b want=0/0/1",
                        s_wready, got_q.size(), t_valid);
                end
                mode = 0;
            end
        join
        wait_got(3, ok);
        n_checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL stallw_count got=%0d want=3", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin errors++; $display("FAIL stallw_beat got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        beat_t e, g;
        mode = 0;
        issue_ar(32'h180, 1'b0, 8'd3);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin @(negedge aclk); ok = (got_q.size() >= 2); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if ({m_awvalid, m_arvalid, m_wvalid, s_rvalid, t_valid} !== 5'b0) begin
            errors++; $display("FAIL midreset_valids got=%b want=00000",
                {m_awvalid, m_arvalid, m_wvalid, s_rvalid, t_valid});
        end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        got_q.delete(); r_got.delete(); exp_q.delete();
        repeat (5) @(negedge aclk);
        n_checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL midreset_stray got=%0d want=0", got_q.size()); end
        exp_q.push_back(mk(32'h300, 4'hF, 2'b11, 1'b1, 1'b0));
        exp_q.push_back(mk(init_word(8'hC0), 4'hF, 2'b01, 1'b1, 1'b1));
        issue_ar(32'h300, 1'b1, 8'd0);
        wait_got(2, ok);
        n_checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL postreset_count got=%0d want=2", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin errors++; $display("FAIL postreset_beat got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        s_awid = 1'b0; s_awaddr = 32'h0; s_awlen = 8'd0; s_awsize = 3'd2; s_awburst = 2'b01;
        s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_arid = 1'b0; s_araddr = 32'h0; s_arlen = 8'd0; s_arsize = 3'd2;
        s_arburst = 2'b01; s_arvalid = 1'b0; s_rready = 1'b1; t_ready = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_collision();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
